// File: rtl/hd44780_phy_mc_if.sv
// Sequencer-side instruction stream and read-data return of the HD44780 bus PHY.
// The master is the command sequencer, the slave is the PHY.
interface hd44780_phy_mc_if #(
  parameter int NUM_E      = 1,
  parameter int DATA_WIDTH = 8
);
  localparam int ESEL_W = ($clog2(NUM_E) > 0) ? $clog2(NUM_E) : 1;

  logic [ESEL_W+2+DATA_WIDTH-1:0] lcd_instr;   // {esel, RS, RWB, DB}
  logic                           valid_instr;
  logic                           ready_instr;
  logic [DATA_WIDTH-1:0]          rdata;
  logic                           rdata_valid;

  modport master (
    output lcd_instr, valid_instr,
    input  ready_instr, rdata, rdata_valid
  );

  modport slave (
    input  lcd_instr, valid_instr,
    output ready_instr, rdata, rdata_valid
  );
endinterface

// File: rtl/hd44780_phy_mc.sv
// HD44780U bus PHY: runs one valid/ready instruction through ADDR / E-high / E-low phases
// on tick-based timing, with runtime 4-bit/8-bit bus mode and NUM_E enable strobes.
module hd44780_phy_mc #(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_E           = 1,
  parameter int PRESCALER_WIDTH = 16,
  parameter int CNT_WIDTH       = 8,
  parameter int ADDR_SETUP_CNT  = 6,
  parameter int EN_PW_CNT       = 45,
  parameter int E_CYCLE_CNT     = 100,
  parameter int RDATA_DELAY_CNT = 36
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [PRESCALER_WIDTH-1:0] prescaler_10ns_i,
  input  logic                       phy_enable_i,
  input  logic                       nibble_mode_i,
  hd44780_phy_mc_if.slave            instr_bus,
  output logic [DATA_WIDTH-1:0]      data_out_o,
  input  logic [DATA_WIDTH-1:0]      data_in_i,
  output logic                       rs_o,
  output logic                       rwb_o,
  output logic [NUM_E-1:0]           e_o,
  output logic                       data_oe_o
);
  localparam int ESEL_W  = ($clog2(NUM_E) > 0) ? $clog2(NUM_E) : 1;
  localparam int INSTR_W = ESEL_W + 2 + DATA_WIDTH;
  localparam int NIB_W   = DATA_WIDTH / 2;

  localparam logic [CNT_WIDTH-1:0] ADDR_LAST = CNT_WIDTH'(ADDR_SETUP_CNT - 1);
  localparam logic [CNT_WIDTH-1:0] HI_LAST   = CNT_WIDTH'(EN_PW_CNT - 1);
  localparam logic [CNT_WIDTH-1:0] LOW_LAST  = CNT_WIDTH'(E_CYCLE_CNT - EN_PW_CNT - 1);
  localparam logic [CNT_WIDTH-1:0] SAMPLE_AT = CNT_WIDTH'(RDATA_DELAY_CNT);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_WR_HI = 3'd2;
  localparam logic [2:0] ST_RD_HI = 3'd3;
  localparam logic [2:0] ST_E_LOW = 3'd4;

  logic [2:0]                 state_reg, state_next;
  logic [PRESCALER_WIDTH-1:0] presc_cnt_reg;
  logic [CNT_WIDTH-1:0]       ph_cnt_reg;

  // Latched instruction fields
  logic [ESEL_W-1:0]          esel_reg;
  logic                       rs_f_reg;
  logic                       rwb_f_reg;
  logic [DATA_WIDTH-1:0]      db_reg;
  logic                       nib_mode_reg;
  logic                       nib_idx_reg;

  // Registered pins and read return
  logic                       rs_reg, rs_next;
  logic                       rwb_reg, rwb_next;
  logic [NUM_E-1:0]           e_reg, e_next;
  logic                       data_oe_reg, data_oe_next;
  logic [DATA_WIDTH-1:0]      data_out_reg, data_out_next;
  logic [DATA_WIDTH-1:0]      rdata_reg;
  logic                       rdata_valid_reg;

  logic [INSTR_W-1:0]         instr;
  logic [PRESCALER_WIDTH-1:0] presc_last;
  logic [CNT_WIDTH-1:0]       phase_last;
  logic                       tick;
  logic                       phase_done;
  logic                       last_nib;
  logic                       ready;
  logic                       accept;
  logic                       nib_advance;
  logic                       e_phase;
  logic                       capture;
  logic [DATA_WIDTH-1:0]      wdata;

  assign instr = instr_bus.lcd_instr;

  // A prescaler of 0 behaves as 1: tick every clock.
  assign presc_last = (prescaler_10ns_i == '0) ? '0
                                               : prescaler_10ns_i - PRESCALER_WIDTH'(1);
  assign tick = (presc_cnt_reg >= presc_last);

  always_comb begin
    phase_last = '0;
    case (state_reg)
      ST_ADDR:             phase_last = ADDR_LAST;
      ST_WR_HI, ST_RD_HI:  phase_last = HI_LAST;
      ST_E_LOW:            phase_last = LOW_LAST;
      default:             phase_last = '0;
    endcase
  end

  assign phase_done  = tick && (ph_cnt_reg == phase_last);
  assign last_nib    = !nib_mode_reg || nib_idx_reg;
  assign ready       = phy_enable_i &&
                       ((state_reg == ST_IDLE) ||
                        ((state_reg == ST_E_LOW) && last_nib && phase_done));
  assign accept      = instr_bus.valid_instr && ready;
  assign nib_advance = (state_reg == ST_E_LOW) && phase_done && nib_mode_reg && !nib_idx_reg;

  assign instr_bus.ready_instr = ready;
  assign instr_bus.rdata       = rdata_reg;
  assign instr_bus.rdata_valid = rdata_valid_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = ST_ADDR;
      end
      ST_ADDR: begin
        if (phase_done) state_next = rwb_f_reg ? ST_RD_HI : ST_WR_HI;
      end
      ST_WR_HI, ST_RD_HI: begin
        if (phase_done) state_next = ST_E_LOW;
      end
      ST_E_LOW: begin
        // Second nibble reuses the address phase of the first.
        if (nib_advance)      state_next = rwb_f_reg ? ST_RD_HI : ST_WR_HI;
        else if (phase_done)  state_next = accept ? ST_ADDR : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg     <= ST_IDLE;
      presc_cnt_reg <= '0;
      ph_cnt_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_next != state_reg) || (state_reg == ST_IDLE)) begin
        presc_cnt_reg <= '0;
        ph_cnt_reg    <= '0;
      end else if (tick) begin
        presc_cnt_reg <= '0;
        ph_cnt_reg    <= ph_cnt_reg + CNT_WIDTH'(1);
      end else begin
        presc_cnt_reg <= presc_cnt_reg + PRESCALER_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      esel_reg     <= '0;
      rs_f_reg     <= 1'b0;
      rwb_f_reg    <= 1'b0;
      db_reg       <= '0;
      nib_mode_reg <= 1'b0;
      nib_idx_reg  <= 1'b0;
    end else if (accept) begin
      esel_reg     <= instr[INSTR_W-1 -: ESEL_W];
      rs_f_reg     <= instr[DATA_WIDTH+1];
      rwb_f_reg    <= instr[DATA_WIDTH];
      db_reg       <= instr[DATA_WIDTH-1:0];
      nib_mode_reg <= nibble_mode_i;
      nib_idx_reg  <= 1'b0;
    end else if (nib_advance) begin
      nib_idx_reg  <= 1'b1;
    end
  end

  // In 4-bit mode only the upper half of the bus carries the nibble.
  always_comb begin
    wdata = db_reg;
    if (nib_mode_reg) begin
      if (!nib_idx_reg) wdata = {db_reg[DATA_WIDTH-1:NIB_W], {NIB_W{1'b0}}};
      else              wdata = {db_reg[NIB_W-1:0],          {NIB_W{1'b0}}};
    end
  end

  assign e_phase = (state_reg == ST_WR_HI) || (state_reg == ST_RD_HI);

  for (genvar gi = 0; gi < NUM_E; gi++) begin : g_e_sel
    assign e_next[gi] = e_phase && (esel_reg == ESEL_W'(gi));
  end

  always_comb begin
    rs_next       = rs_reg;
    rwb_next      = rwb_reg;
    data_out_next = data_out_reg;
    data_oe_next  = 1'b0;
    case (state_reg)
      ST_ADDR: begin
        rs_next  = rs_f_reg;
        rwb_next = rwb_f_reg;
      end
      ST_WR_HI: begin
        data_oe_next  = 1'b1;
        data_out_next = wdata;
      end
      ST_E_LOW: data_oe_next = data_oe_reg;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rs_reg       <= 1'b0;
      rwb_reg      <= 1'b0;
      e_reg        <= '0;
      data_oe_reg  <= 1'b0;
      data_out_reg <= '0;
    end else begin
      rs_reg       <= rs_next;
      rwb_reg      <= rwb_next;
      e_reg        <= e_next;
      data_oe_reg  <= data_oe_next;
      data_out_reg <= data_out_next;
    end
  end

  assign capture = (state_reg == ST_RD_HI) && tick && (ph_cnt_reg == SAMPLE_AT);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rdata_reg       <= '0;
      rdata_valid_reg <= 1'b0;
    end else begin
      if (capture) begin
        if (!nib_mode_reg)
          rdata_reg <= data_in_i;
        else if (!nib_idx_reg)
          rdata_reg[DATA_WIDTH-1:NIB_W] <= data_in_i[DATA_WIDTH-1:NIB_W];
        else
          rdata_reg[NIB_W-1:0] <= data_in_i[DATA_WIDTH-1:NIB_W];
      end
      rdata_valid_reg <= capture && last_nib;
    end
  end

  assign rs_o       = rs_reg;
  assign rwb_o      = rwb_reg;
  assign e_o        = e_reg;
  assign data_oe_o  = data_oe_reg;
  assign data_out_o = data_out_reg;
endmodule
